// File: rtl/adsr_pkg.sv
// Shared encodings for the multi-voice ADSR envelope generator.
package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    function automatic logic [31:0] env_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/adsr_env_step.sv
// One envelope update: gate transition first, then the step of the resulting state.
module adsr_env_step
    import adsr_pkg::*;
#(
    parameter int ENV_W = 16
) (
    input  adsr_state_t      state_i,
    input  logic [ENV_W-1:0] env_i,
    input  logic             gate_i,
    input  logic             gate_prev_i,
    input  logic [ENV_W-1:0] attack_step_i,
    input  logic [ENV_W-1:0] decay_step_i,
    input  logic [ENV_W-1:0] release_step_i,
    input  logic [ENV_W-1:0] sustain_level_i,
    output adsr_state_t      state_o,
    output logic [ENV_W-1:0] env_o
);

    localparam logic [ENV_W-1:0] ENV_MAX = ENV_W'(env_max(ENV_W));

    adsr_state_t    st;
    logic [ENV_W:0] att_sum;
    logic [ENV_W:0] dec_floor;

    always_comb begin
        st = state_i;
        if (gate_i && !gate_prev_i) begin
            st = ST_ATTACK;
        end else if (!gate_i && (st == ST_ATTACK || st == ST_DECAY || st == ST_SUSTAIN)) begin
            st = ST_RELEASE;
        end

        // Both sums carry an extra bit so the clamp/compare never wraps.
        att_sum   = {1'b0, env_i} + {1'b0, attack_step_i};
        dec_floor = {1'b0, sustain_level_i} + {1'b0, decay_step_i};

        state_o = st;
        env_o   = env_i;
        case (st)
            ST_ATTACK: begin
                if (att_sum >= {1'b0, ENV_MAX}) begin
                    env_o   = ENV_MAX;
                    state_o = ST_DECAY;
                end else begin
                    env_o = att_sum[ENV_W-1:0];
                end
            end
            ST_DECAY: begin
                if ({1'b0, env_i} <= dec_floor) begin
                    env_o   = sustain_level_i;
                    state_o = ST_SUSTAIN;
                end else begin
                    env_o = env_i - decay_step_i;
                end
            end
            ST_SUSTAIN: env_o = sustain_level_i;
            ST_RELEASE: begin
                if (env_i <= release_step_i) begin
                    env_o   = '0;
                    state_o = ST_IDLE;
                end else begin
                    env_o = env_i - release_step_i;
                end
            end
            default: begin
                env_o   = '0;
                state_o = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/adsr_multi.sv
// Multi-voice ADSR envelope + saturating mixer; voices are updated one per cycle
// through a single envelope-step block and a single multiplier.
module adsr_multi
    import adsr_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16,
    parameter int ENV_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] sample_in,
    input  logic                    in_ready,
    input  logic [NUM_CH-1:0]       gate,
    input  logic [ENV_W-1:0]        attack_step,
    input  logic [ENV_W-1:0]        decay_step,
    input  logic [ENV_W-1:0]        release_step,
    input  logic [ENV_W-1:0]        sustain_level,
    output logic [NUM_CH*WIDTH-1:0] sample_out,
    output logic [WIDTH-1:0]        mix_out,
    output logic                    out_ready,
    output logic                    busy,
    output logic [NUM_CH-1:0]       active,
    output logic                    overrun
);

    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = WIDTH + $clog2(NUM_CH);
    localparam int PW    = WIDTH + ENV_W + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

    seq_state_t                     seq_q, seq_d;
    logic [CW-1:0]                  idx_q;
    logic [NUM_CH-1:0][WIDTH-1:0]   snap_q, res_q, sample_out_q, out_d;
    logic [NUM_CH-1:0]              gsnap_q, gate_prev_q, active_q, active_d;
    logic [NUM_CH-1:0][ENV_W-1:0]   env_q;
    adsr_state_t                    state_q [NUM_CH];
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]               mix_q, mix_d;
    logic                           overrun_q;

    logic                           accept, running, last;
    adsr_state_t                    st_nxt;
    logic [ENV_W-1:0]               env_nxt;
    logic signed [PW-1:0]           samp_x, env_x, prod;
    logic signed [WIDTH-1:0]        scaled;
    logic                           prod_unused;

    assign running = (seq_q == SEQ_RUN);
    assign accept  = in_ready && !running;
    assign last    = running && (idx_q == LAST);

    always_comb begin
        seq_d = seq_q;
        case (seq_q)
            SEQ_RUN: if (idx_q == LAST) seq_d = SEQ_DONE;
            default: seq_d = in_ready ? SEQ_RUN : SEQ_IDLE;
        endcase
    end

    adsr_env_step #(.ENV_W(ENV_W)) u_step (
        .state_i        (state_q[idx_q]),
        .env_i          (env_q[idx_q]),
        .gate_i         (gsnap_q[idx_q]),
        .gate_prev_i    (gate_prev_q[idx_q]),
        .attack_step_i  (attack_step),
        .decay_step_i   (decay_step),
        .release_step_i (release_step),
        .sustain_level_i(sustain_level),
        .state_o        (st_nxt),
        .env_o          (env_nxt)
    );

    // Signed sample times zero-extended envelope; taking bits above ENV_W is a floor shift.
    always_comb begin
        samp_x = PW'($signed(snap_q[idx_q]));
        env_x  = $signed(PW'(env_nxt));
        prod   = samp_x * env_x;
        scaled = prod[ENV_W +: WIDTH];
    end
    assign prod_unused = ^{prod[PW-1:ENV_W+WIDTH], prod[ENV_W-1:0]};

    always_comb begin
        acc_d = ((idx_q == '0) ? '0 : acc_q) + ACC_W'(scaled);
        if (acc_d[ACC_W-1:WIDTH-1] == {(ACC_W-WIDTH+1){acc_d[ACC_W-1]}}) begin
            mix_d = acc_d[WIDTH-1:0];
        end else begin
            mix_d = acc_d[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        out_d    = res_q;
        active_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CW'(c) == idx_q) begin
                out_d[c]    = scaled;
                active_d[c] = (st_nxt != ST_IDLE);
            end else begin
                active_d[c] = (state_q[c] != ST_IDLE);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q        <= SEQ_IDLE;
            idx_q        <= '0;
            snap_q       <= '0;
            gsnap_q      <= '0;
            gate_prev_q  <= '0;
            env_q        <= '0;
            res_q        <= '0;
            acc_q        <= '0;
            sample_out_q <= '0;
            mix_q        <= '0;
            active_q     <= '0;
            overrun_q    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) state_q[c] <= ST_IDLE;
        end else begin
            seq_q <= seq_d;
            if (in_ready && running) overrun_q <= 1'b1;
            if (accept) begin
                snap_q  <= sample_in;
                gsnap_q <= gate;
                idx_q   <= '0;
            end
            if (running) begin
                state_q[idx_q]     <= st_nxt;
                env_q[idx_q]       <= env_nxt;
                gate_prev_q[idx_q] <= gsnap_q[idx_q];
                res_q[idx_q]       <= scaled;
                acc_q              <= acc_d;
                idx_q              <= idx_q + 1'b1;
                if (last) begin
                    sample_out_q <= out_d;
                    mix_q        <= mix_d;
                    active_q     <= active_d;
                end
            end
        end
    end

    assign sample_out = sample_out_q;
    assign mix_out    = mix_q;
    assign active     = active_q;
    assign out_ready  = (seq_q == SEQ_DONE);
    assign busy       = running;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adsr_multi.sv
// Randomized + directed bench for adsr_multi against a behavioural envelope model.
module tb_adsr_multi;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 16;
    localparam int ENV_W  = 16;
    localparam int EMAX   = (1 << ENV_W) - 1;
    localparam longint SCL = longint'(1) << ENV_W;
    localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH*WIDTH-1:0] sample_in;
    logic                    in_ready;
    logic [NUM_CH-1:0]       gate;
    logic [ENV_W-1:0]        attack_step, decay_step, release_step, sustain_level;
    logic [NUM_CH*WIDTH-1:0] sample_out;
    logic [WIDTH-1:0]        mix_out;
    logic                    out_ready, busy, overrun;
    logic [NUM_CH-1:0]       active;

    adsr_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ENV_W(ENV_W)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .in_ready(in_ready), .gate(gate),
        .attack_step(attack_step), .decay_step(decay_step), .release_step(release_step),
        .sustain_level(sustain_level), .sample_out(sample_out), .mix_out(mix_out),
        .out_ready(out_ready), .busy(busy), .active(active), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_tot = 0, n_bad = 0;

    // model of the envelope per voice
    int               m_st  [NUM_CH];
    int               m_env [NUM_CH];
    bit               m_gp  [NUM_CH];
    logic [WIDTH-1:0] e_out [NUM_CH];
    logic [WIDTH-1:0] e_mix;
    logic [NUM_CH-1:0] e_act;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = M_IDLE; m_env[c] = 0; m_gp[c] = 0; e_out[c] = '0;
        end
        e_mix = '0; e_act = '0;
    endfunction

    function automatic void model_pass(input logic [NUM_CH-1:0][WIDTH-1:0] smp,
                                       input logic [NUM_CH-1:0] g);
        longint sum = 0, p, q;
        int s, e;
        for (int c = 0; c < NUM_CH; c++) begin
            s = m_st[c]; e = m_env[c];
            if (g[c] && !m_gp[c]) s = M_ATK;
            else if (!g[c] && (s == M_ATK || s == M_DEC || s == M_SUS)) s = M_REL;
            case (s)
                M_ATK: begin
                    e = e + int'(attack_step);
                    if (e >= EMAX) begin e = EMAX; s = M_DEC; end
                end
                M_DEC: begin
                    if (e <= int'(sustain_level) + int'(decay_step)) begin
                        e = int'(sustain_level); s = M_SUS;
                    end else e = e - int'(decay_step);
                end
                M_SUS: e = int'(sustain_level);
                M_REL: begin
                    e = e - int'(release_step);
                    if (e <= 0) begin e = 0; s = M_IDLE; end
                end
                default: e = 0;
            endcase
            m_st[c] = s; m_env[c] = e; m_gp[c] = g[c];
            p = longint'($signed(smp[c])) * longint'(e);
            q = p / SCL;
            if (p < 0 && (p % SCL) != 0) q = q - 1;
            e_out[c] = q[WIDTH-1:0];
            e_act[c] = (s != M_IDLE);
            sum += q;
        end
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        e_mix = sum[WIDTH-1:0];
    endfunction

    task automatic cmp_outputs(input string tag);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("%s_out%0d", tag, c), sample_out[c*WIDTH +: WIDTH], e_out[c]);
        chk({tag, "_mix"}, mix_out, e_mix);
        chk({tag, "_active"}, active, e_act);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sout"}, sample_out, 0);
        chk({tag, "_mix"}, mix_out, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_ordy"}, out_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    // Called #1 after a clock edge; returns #1 after the out_ready edge.
    task automatic do_pass(input logic [NUM_CH-1:0][WIDTH-1:0] smp,
                           input logic [NUM_CH-1:0] g, input string tag);
        int lat;
        sample_in = smp; gate = g; in_ready = 1'b1;
        @(posedge clk); #1 in_ready = 1'b0;
        model_pass(smp, g);
        sample_in = {$urandom, $urandom};
        gate      = NUM_CH'($urandom);
        chk({tag, "_busy1"}, busy, 1);
        lat = 0;
        while (!out_ready && lat < NUM_CH + 4) begin
            @(posedge clk); #1 lat++;
        end
        chk({tag, "_lat"}, lat, NUM_CH);
        chk({tag, "_busy0"}, busy, 0);
        cmp_outputs(tag);
    endtask

    function automatic logic [ENV_W-1:0] pick_rate();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return ENV_W'($urandom_range(1, 255));
            2: return ENV_W'($urandom_range(256, 8191));
            default: return ENV_W'($urandom_range(0, EMAX));
        endcase
    endfunction

    logic [NUM_CH-1:0][WIDTH-1:0] smp;
    logic [NUM_CH-1:0]            gr;
    logic [15:0]                  tab [10];
    int pulses, hit;

    initial begin
        tab = '{16'h1000, 16'h2000, 16'h3000, 16'h3FFF, 16'h3BFF,
                16'h37FF, 16'h33FF, 16'h3000, 16'h1800, 16'h0000};
        reset = 1'b1; in_ready = 1'b0; gate = '0; sample_in = '0;
        attack_step = '0; decay_step = '0; release_step = '0; sustain_level = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_zero("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        // idle channels produce silence
        smp = {NUM_CH{16'h4000}};
        do_pass(smp, '0, "t1");

        // attack, decay to sustain, release on voice 0
        attack_step = 16'h4000; decay_step = 16'h1000;
        sustain_level = 16'hC000; release_step = 16'h6000;
        for (int i = 0; i < 10; i++) begin
            do_pass(smp, (i < 8) ? 4'b0001 : 4'b0000, $sformatf("t2_%0d", i));
            chk($sformatf("t2_tab%0d", i), sample_out[15:0], tab[i]);
        end
        chk("t3_act0", active[0], 0);

        // full-scale envelope, saturating mix
        attack_step = 16'hFFFF; decay_step = 16'h0000; sustain_level = 16'hFFFF;
        do_pass({NUM_CH{16'h7FFF}}, '1, "t4p");
        chk("t4p_out0", sample_out[15:0], 16'h7FFE);
        chk("t4p_mix", mix_out, 16'h7FFF);
        do_pass({NUM_CH{16'h8000}}, '1, "t4n");
        chk("t4n_out3", sample_out[63:48], 16'h8000);
        chk("t4n_mix", mix_out, 16'h8000);

        // strobe while busy is dropped and flagged
        smp = {NUM_CH{16'h2000}};
        sample_in = smp; gate = '1; in_ready = 1'b1;
        @(posedge clk); #1 in_ready = 1'b0;
        model_pass(smp, '1);
        @(posedge clk); #1 in_ready = 1'b1;
        @(posedge clk); #1 in_ready = 1'b0;
        chk("t5_busy", busy, 1);
        pulses = 0; hit = 0;
        for (int k = 3; k <= 9; k++) begin
            @(posedge clk); #1;
            if (out_ready) begin
                pulses++; hit = k;
                if (pulses == 1) cmp_outputs("t5");
            end
        end
        chk("t5_pulses", pulses, 1);
        chk("t5_at", hit, NUM_CH);
        chk("t5_ovr", overrun, 1);

        // reset in the middle of a pass discards it
        in_ready = 1'b1;
        @(posedge clk); #1 in_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_ready) pulses++;
        end
        chk("t5r_pulses", pulses, 0);
        chk_zero("t5r");

        // retrigger during release keeps the current level
        smp = {NUM_CH{16'h4000}};
        attack_step = 16'hFFFF;
        do_pass(smp, 4'b0010, "t6a");
        sustain_level = 16'hC000; decay_step = 16'h4000;
        do_pass(smp, 4'b0010, "t6b");
        release_step = 16'h6000;
        do_pass(smp, 4'b0000, "t6c");
        attack_step = 16'h1000;
        do_pass(smp, 4'b0010, "t6d");
        chk("t6_out1", sample_out[31:16], 16'h1C00);
        chk("t6_act1", active[1], 1);

        // random passes, occasionally back-to-back
        gr = '0;
        for (int i = 0; i < 80; i++) begin
            attack_step = pick_rate(); decay_step = pick_rate();
            release_step = pick_rate();
            sustain_level = ($urandom_range(0, 4) == 0) ? 16'hFFFF : ENV_W'($urandom);
            gr = gr ^ NUM_CH'($urandom & $urandom);
            for (int c = 0; c < NUM_CH; c++) begin
                case ($urandom_range(0, 9))
                    0: smp[c] = 16'h7FFF;
                    1: smp[c] = 16'h8000;
                    default: smp[c] = WIDTH'($urandom);
                endcase
            end
            do_pass(smp, gr, $sformatf("r%0d", i));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        chk("r_ovr", overrun, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
